// File: rtl/dig_out_shaper_pkg.sv
// Shared definitions for the digital output shaper.
//    ST_STABLE / ST_HOLD : shaper FSM state encoding
//    W_DEFAULT           : hold-counter width, matched to the input filter's
//                          FILTER width so paired HOLD/FILTER settings line up
//    ON_W                : width of the saturating max-on-time counter
//    hold_eff()          : HOLD value actually applied (0 behaves as 1)
package dig_out_shaper_pkg;

   localparam int W_DEFAULT = 5;
   localparam int ON_W      = 16;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_HOLD   = 1'b1
   } state_t;

   function automatic int hold_eff(input int hold);
      return (hold == 0) ? 1 : hold;
   endfunction

endpackage

// File: rtl/dig_out_hold_timer.sv
// Loadable W-bit timer used twice by the shaper: as the hold down-counter
// and, with UP = 1, as the saturating on-time up-counter.
//    clk, reset_n : system clock, async active-low reset (count clears)
//    load         : load load_val this edge (wins over counting)
//    load_val     : value to load
//    en           : count one step this edge
//    count        : current value
//    zero         : count == 0
// Down mode stops at 0; up mode stops at all-ones. Neither direction wraps.
module dig_out_hold_timer
   import dig_out_shaper_pkg::*;
#(
   parameter int W  = W_DEFAULT,
   parameter bit UP = 1'b0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         if (UP) begin
            if (count != '1) count <= count + W'(1);
         end else begin
            if (count != '0) count <= count - W'(1);
         end
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/dig_out_shaper.sv
// Digital output shaper: turns a logic-level request into a physical output
// that never changes level more often than once per HOLD+1 clocks, with
// optional inversion and a sticky maximum-on-time cutoff.
//    clk     : system clock
//    reset_n : async active-low reset
//    in      : requested logical level
//    out     : shaped physical output (lvl ^ INVERT, registered level)
//    busy    : hold timer running, no level change permitted yet
//    fault   : sticky, MAX_ON cutoff has fired; clears once in = 0 and lvl = 0
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_STABLE | lvl may follow eff_req on this edge
// ST_HOLD   | lvl frozen, hold timer counting down; leave when it reads 0
module dig_out_shaper
   import dig_out_shaper_pkg::*;
#(
   parameter int           W      = W_DEFAULT,
   parameter logic [W-1:0] HOLD   = W'(5),
   parameter logic [15:0]  MAX_ON = 16'd0,
   parameter bit           INVERT = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in,
   output logic out,
   output logic busy,
   output logic fault
);

   // Loaded on a level change; HOLD-1 more edges in ST_HOLD plus the exit
   // edge give exactly HOLD edges without a change.
   localparam logic [W-1:0] HOLD_RELOAD = W'(hold_eff(int'(HOLD)) - 1);

   state_t          state, state_nxt;
   logic            lvl, lvl_nxt;
   logic            fault_q, fault_nxt;
   logic            eff_req;
   logic            timeout;
   logic            hold_load;
   logic            hold_zero;
   logic [W-1:0]    hold_count;
   logic [ON_W-1:0] on_cnt;
   logic            on_zero;
   logic            unused_sigs;

   dig_out_hold_timer #(
      .W  (W),
      .UP (1'b0)
   ) u_hold_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (hold_load),
      .load_val (HOLD_RELOAD),
      .en       (state == ST_HOLD),
      .count    (hold_count),
      .zero     (hold_zero)
   );

   // Counts clocks spent with lvl = 1; held at 0 while lvl = 0.
   dig_out_hold_timer #(
      .W  (ON_W),
      .UP (1'b1)
   ) u_on_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (~lvl),
      .load_val ('0),
      .en       (lvl),
      .count    (on_cnt),
      .zero     (on_zero)
   );

   assign unused_sigs = ^{hold_count, on_zero};

   // Fires on the edge where the on-time reaches MAX_ON, so lvl is high for
   // exactly MAX_ON clocks when no hold is in the way.
   assign timeout = (MAX_ON != 16'd0) && lvl &&
                    (({1'b0, on_cnt} + 17'd1) >= {1'b0, MAX_ON});

   assign eff_req = in & ~fault_q & ~timeout;

   always_comb begin
      state_nxt = state;
      lvl_nxt   = lvl;
      hold_load = 1'b0;
      fault_nxt = fault_q;

      case (state)
         ST_STABLE: begin
            if (eff_req != lvl) begin
               lvl_nxt   = eff_req;
               hold_load = 1'b1;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_zero) state_nxt = ST_STABLE;
         end
      endcase

      // Set needs lvl = 1 and clear needs lvl = 0, so they never collide.
      if (timeout)
         fault_nxt = 1'b1;
      else if (!in && !lvl)
         fault_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_STABLE;
         lvl     <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         lvl     <= lvl_nxt;
         fault_q <= fault_nxt;
      end
   end

   assign out   = lvl ^ INVERT;
   assign busy  = (state == ST_HOLD);
   assign fault = fault_q;

endmodule
